// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and constants for the I2C write-only target.
package i2c_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } i2c_state_e;
    localparam int   I2C_BITS_PER_BYTE = 8;
    localparam logic RW_WRITE          = 1'b0;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-flop synchronizer plus previous-value flop giving one-clock edge pulses.
//   clk_i, rst_i : system clock, async active-high reset
//   line_i       : raw asynchronous bus wire
//   sync_o       : synchronized level
//   rise_o/fall_o: one-clock pulses on synchronized edges
module i2c_line_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic meta_q, sync_q, prev_q;
    // Reset to the idle bus level so leaving reset never fakes a bus edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end
    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/i2c_slave_receiver.sv
// i2c_slave_receiver: write-only I2C target; ACKs its address and each data byte, emits bytes with a valid pulse.
//   clock, Reset : system clock, async active-high reset
//   SCL, SDA_in  : raw bus wires, sampled as data (SCL is never used as a clock)
//   SDA_oe       : 1 pulls SDA low (open drain)
//   RxData/RxValid: received byte and its one-clock strobe
//   AddrMatch    : address acknowledged, until next START/STOP
//   Busy         : between START and STOP
module i2c_slave_receiver
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       SCL,
    input  logic       SDA_in,
    output logic       SDA_oe,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       AddrMatch,
    output logic       Busy
);
    logic scl_sync, scl_rise, scl_fall;
    logic sda_sync, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk_i (clock),
        .rst_i (Reset),
        .line_i(SCL),
        .sync_o(scl_sync),
        .rise_o(scl_rise),
        .fall_o(scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk_i (clock),
        .rst_i (Reset),
        .line_i(SDA_in),
        .sync_o(sda_sync),
        .rise_o(sda_rise),
        .fall_o(sda_fall)
    );

    i2c_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       addr_match_q, addr_match_d;
    logic       busy_q, busy_d;

    logic start_det, stop_det, byte_done, addr_ok;
    assign start_det = sda_fall & scl_sync;
    assign stop_det  = sda_rise & scl_sync;
    assign byte_done = cnt_q == 4'(I2C_BITS_PER_BYTE);
    assign addr_ok   = (shift_q[7:1] == SLAVE_ADDR) && (shift_q[0] == RW_WRITE);

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            sda_oe_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            sda_oe_q     <= sda_oe_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            busy_q       <= busy_d;
        end
    end

    // START/STOP override any bit activity in the same clock; SDA_oe otherwise
    // only moves on SCL falls, keeping SDA stable while SCL is high.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        sda_oe_d     = sda_oe_q;
        rx_valid_d   = 1'b0;
        addr_match_d = addr_match_q;
        busy_d       = busy_q;
        if (start_det) begin
            state_d      = ADDR;
            cnt_d        = '0;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b1;
            addr_match_d = 1'b0;
        end else if (stop_det) begin
            state_d      = IDLE;
            cnt_d        = '0;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
        end else begin
            if (scl_rise && (state_q == ADDR || state_q == DATA)) begin
                shift_d = {shift_q[6:0], sda_sync};
                cnt_d   = cnt_q + 4'd1;
            end
            if (scl_fall) begin
                case (state_q)
                    ADDR: begin
                        if (byte_done) begin
                            state_d      = addr_ok ? ADDR_ACK : IGNORE;
                            sda_oe_d     = addr_ok;
                            addr_match_d = addr_ok;
                        end
                    end
                    DATA: begin
                        if (byte_done) begin
                            state_d    = DATA_ACK;
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_oe_d   = 1'b1;
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        state_d  = DATA;
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign SDA_oe    = sda_oe_q;
    assign RxData    = rx_data_q;
    assign RxValid   = rx_valid_q;
    assign AddrMatch = addr_match_q;
    assign Busy      = busy_q;
endmodule

// File: tb/tb_i2c_slave_receiver.sv
// tb_i2c_slave_receiver: directed bus-master scenarios against the I2C write-only target.
module tb_i2c_slave_receiver;
    import i2c_pkg::*;

    localparam int Q = 6;

    logic       clock = 1'b0;
    logic       Reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b1;
    logic       SDA_oe;
    logic [7:0] RxData;
    logic       RxValid;
    logic       AddrMatch;
    logic       Busy;
    logic       sda_line;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] rx_q[$];
    logic oe_seen;

    assign sda_line = sda_drv & ~SDA_oe;

    i2c_slave_receiver #(.SLAVE_ADDR(7'h3C)) dut (
        .clock    (clock),
        .Reset    (Reset),
        .SCL      (scl),
        .SDA_in   (sda_line),
        .SDA_oe   (SDA_oe),
        .RxData   (RxData),
        .RxValid  (RxValid),
        .AddrMatch(AddrMatch),
        .Busy     (Busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (RxValid) rx_q.push_back(RxData);
        if (SDA_oe) oe_seen = 1'b1;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic hold();
        repeat (Q) @(negedge clock);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; hold();
        scl = 1'b1; hold();
        sda_drv = 1'b0; hold();
        scl = 1'b0; hold();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; hold();
        scl = 1'b1; hold();
        sda_drv = 1'b1; hold();
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b; hold();
        scl = 1'b1; hold();
        scl = 1'b0; hold();
    endtask

    task automatic write_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
    endtask

    task automatic ack_bit(input string name, input logic exp);
        sda_drv = 1'b1; hold();
        scl = 1'b1; hold();
        vectors++;
        if (SDA_oe !== exp) begin
            miscompares++;
            $display("FAIL %s: SDA_oe=%b expected %b", name, SDA_oe, exp);
        end
        scl = 1'b0; hold();
    endtask

    task automatic begin_test();
        rx_q.delete();
        oe_seen = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({SDA_oe, RxData, RxValid, AddrMatch, Busy} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 000", {SDA_oe, RxData, RxValid, AddrMatch, Busy});
        end
        vectors++;
        if (dut.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_single_write();
        begin_test();
        bus_start();
        vectors++;
        if (Busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", Busy); end
        write_byte(8'h78);
        ack_bit("single_addr_ack", 1'b1);
        vectors++;
        if (AddrMatch !== 1'b1) begin miscompares++; $display("FAIL single_match: got %b expected 1", AddrMatch); end
        write_byte(8'hA5);
        ack_bit("single_data_ack", 1'b1);
        vectors++;
        if (AddrMatch !== 1'b1) begin miscompares++; $display("FAIL single_match_hold: got %b expected 1", AddrMatch); end
        bus_stop();
        vectors++;
        if (rx_q.size() != 1) begin miscompares++; $display("FAIL single_rx_count: got %0d expected 1", rx_q.size()); end
        else if (rx_q[0] !== 8'hA5) begin miscompares++; $display("FAIL single_rx_byte: got %h expected a5", rx_q[0]); end
        vectors++;
        if (RxData !== 8'hA5) begin miscompares++; $display("FAIL single_rxdata: got %h expected a5", RxData); end
        vectors++;
        if ({AddrMatch, Busy, SDA_oe} !== 3'b000) begin miscompares++; $display("FAIL single_after_stop: got %b expected 000", {AddrMatch, Busy, SDA_oe}); end
    endtask

    task automatic test_wrong_addr();
        begin_test();
        bus_start();
        write_byte(8'h7A);
        ack_bit("wrong_addr_nack", 1'b0);
        vectors++;
        if (dut.state_q !== IGNORE) begin miscompares++; $display("FAIL wrong_state: got %0d expected %0d", dut.state_q, IGNORE); end
        write_byte(8'h11);
        ack_bit("wrong_data_nack", 1'b0);
        bus_stop();
        vectors++;
        if (oe_seen !== 1'b0 || rx_q.size() != 0) begin
            miscompares++;
            $display("FAIL wrong_quiet: oe_seen=%b rx=%0d expected 0 0", oe_seen, rx_q.size());
        end
        vectors++;
        if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL wrong_idle: got %0d expected %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_read_nack();
        begin_test();
        bus_start();
        write_byte(8'h79);
        ack_bit("read_nack", 1'b0);
        vectors++;
        if (AddrMatch !== 1'b0) begin miscompares++; $display("FAIL read_match: got %b expected 0", AddrMatch); end
        write_byte(8'h33);
        bus_stop();
        vectors++;
        if (rx_q.size() != 0) begin miscompares++; $display("FAIL read_rx: got %0d pulses expected 0", rx_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        exp = '{8'h01, 8'h80, 8'hFF};
        begin_test();
        bus_start();
        write_byte(8'h78);
        ack_bit("multi_addr_ack", 1'b1);
        for (int i = 0; i < 3; i++) begin
            write_byte(exp[i]);
            ack_bit("multi_data_ack", 1'b1);
        end
        bus_stop();
        vectors++;
        if (rx_q.size() != 3) begin miscompares++; $display("FAIL multi_count: got %0d expected 3", rx_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (rx_q[i] !== exp[i]) begin miscompares++; $display("FAIL multi_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
            end
        end
    endtask

    task automatic test_stop_midbyte();
        begin_test();
        bus_start();
        write_byte(8'h78);
        ack_bit("mid_addr_ack", 1'b1);
        for (int i = 0; i < 4; i++) write_bit(1'b0);
        bus_stop();
        vectors++;
        if (rx_q.size() != 0) begin miscompares++; $display("FAIL mid_rx: got %0d pulses expected 0", rx_q.size()); end
        vectors++;
        if (RxData !== 8'hFF) begin miscompares++; $display("FAIL mid_rxdata: got %h expected ff", RxData); end
        vectors++;
        if ({SDA_oe, Busy, AddrMatch} !== 3'b000) begin miscompares++; $display("FAIL mid_flags: got %b expected 000", {SDA_oe, Busy, AddrMatch}); end
    endtask

    task automatic test_repeated_start();
        begin_test();
        bus_start();
        write_byte(8'h78);
        ack_bit("rs_first_ack", 1'b1);
        bus_start();
        vectors++;
        if ({dut.state_q, AddrMatch, Busy} !== {ADDR, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rs_restart: state=%0d match=%b busy=%b expected %0d 0 1", dut.state_q, AddrMatch, Busy, ADDR);
        end
        write_byte(8'h78);
        ack_bit("rs_second_ack", 1'b1);
        write_byte(8'h5A);
        ack_bit("rs_data_ack", 1'b1);
        bus_stop();
        vectors++;
        if (rx_q.size() != 1 || RxData !== 8'h5A) begin
            miscompares++;
            $display("FAIL rs_data: pulses=%0d RxData=%h expected 1 5a", rx_q.size(), RxData);
        end
    endtask

    task automatic test_reset_mid();
        begin_test();
        bus_start();
        write_byte(8'h78);
        sda_drv = 1'b1; hold();
        scl = 1'b1; hold();
        vectors++;
        if (SDA_oe !== 1'b1) begin miscompares++; $display("FAIL rst_pre_oe: got %b expected 1", SDA_oe); end
        Reset = 1'b1;
        #1;
        vectors++;
        if (SDA_oe !== 1'b0) begin miscompares++; $display("FAIL rst_async_oe: got %b expected 0", SDA_oe); end
        vectors++;
        if ({RxData, RxValid, AddrMatch, Busy} !== 11'h000 || dut.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL rst_outputs: got %h state=%0d expected 000 %0d", {RxData, RxValid, AddrMatch, Busy}, dut.state_q, IDLE);
        end
        hold();
        Reset = 1'b0;
        hold();
    endtask

    initial begin
        repeat (3) @(negedge clock);
        Reset = 1'b0;
        hold();
        test_reset();
        test_single_write();
        test_wrong_addr();
        test_read_nack();
        test_back_to_back();
        test_stop_midbyte();
        test_repeated_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/i2c_slave_receiver.md
Name: i2c_slave_receiver

Overview:
- Write-only I2C target (responder) that pairs with the team's I2C master write controller.
- Watches the bus wires SCL and SDA, detects START and STOP, and shifts in a 7-bit address and R/W bit.
- When the address matches and the transfer is a write, it ACKs each byte by pulling SDA low and presents every received data byte to the system with a one-cycle valid pulse.
- Sits on the system clock. SCL is treated as a slow, asynchronous data input, never as a clock.

Parameters:
- SLAVE_ADDR, 7'h3C, 7-bit target address that this block acknowledges.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- SCL  input  1  raw I2C clock line, asynchronous to clock.
- SDA_in  input  1  raw I2C data line as read back from the pad, asynchronous.
- SDA_oe  output  1  1 = pull SDA low (open-drain); 0 = release the line.
- RxData  output  8  last received data byte, MSB first on the wire.
- RxValid  output  1  one-clock pulse when RxData updates.
- AddrMatch  output  1  high from the address ACK until the next STOP or START.
- Busy  output  1  high between a detected START and the next STOP.

Behaviour:
- Reset values: SDA_oe=0, RxData=8'h00, RxValid=0, AddrMatch=0, Busy=0, state=IDLE, bit counter=0.
- Input conditioning:
  - SCL and SDA_in each pass through a 2-flop synchronizer, then a registered previous-value flop.
  - SCL_rise, SCL_fall, SDA_rise and SDA_fall are one-clock pulses, so edge latency is 3 clocks.
- START = SDA_fall while synced SCL is 1. STOP = SDA_rise while synced SCL is 1. Both are evaluated in every state and take priority over bit handling.
  - START in any state: go to ADDR, clear the bit counter, SDA_oe=0, Busy=1, AddrMatch=0. This covers repeated START.
  - STOP in any state: go to IDLE, SDA_oe=0, Busy=0, AddrMatch=0.
- Data bits are sampled on SCL_rise. The shift register shifts left and takes the synced SDA value into the LSB.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: sample 8 bits (7 address bits + R/W).
    - On the SCL_fall after the 8th bit: if addr==SLAVE_ADDR and R/W==0, go to ADDR_ACK with SDA_oe=1 and AddrMatch=1.
    - Otherwise go to IGNORE with SDA_oe=0. A read request is NACKed.
  - ADDR_ACK: hold SDA_oe=1 across the 9th clock. On the next SCL_fall, release (SDA_oe=0), clear the counter and go to DATA.
  - DATA: sample 8 bits.
    - On the SCL_fall after the 8th bit: load RxData from the shift register, pulse RxValid for exactly one clock, set SDA_oe=1, go to DATA_ACK.
  - DATA_ACK: on the next SCL_fall, set SDA_oe=0, clear the counter and return to DATA. Multi-byte writes are unbounded.
  - IGNORE: SDA_oe stays 0. Wait for START or STOP.
- Bit counter: 4 bits, counting 0..8. It increments on SCL_rise in ADDR and DATA only, and its value is compared to 8 at SCL_fall. It never wraps without passing through an ACK state.
- SDA_oe changes only on SCL_fall, START or STOP, and never while synced SCL is high (an I2C data-valid rule).
- STOP mid-byte: the partial byte is discarded and no RxValid is produced.
- Simultaneous START and SCL edge in the same clock: START wins.
- Reset mid-transfer releases SDA immediately (asynchronous).
- RxValid latency: 1 clock after the synchronized SCL_fall that ends the 8th data bit.

Decomposition:
- Shared package i2c_pkg:
  - state encoding: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE (3 bits);
  - I2C_BITS_PER_BYTE=8;
  - RW_WRITE=1'b0.
- One sub-module, i2c_line_sync: 2-flop synchronizer plus edge detector. It is instantiated once for SCL and once for SDA_in, and outputs sync, rise and fall. It replaces the team's separate positive and negative one-shots for this block.

Test Plan:
- Write to 0x3C (addr byte 8'h78) with data 8'hA5, then STOP -> SDA_oe high during both ninth clocks; RxData=8'hA5; one RxValid pulse; AddrMatch high until STOP; Busy low after STOP.
- Address 0x3D write, data 8'h11 -> SDA_oe never asserts, no RxValid, state IGNORE until STOP.
- Address 0x3C with R/W=1 (byte 8'h79) -> NACK (SDA_oe=0 on the ninth clock), no RxValid.
- Three-byte write 8'h01, 8'h80, 8'hFF -> three RxValid pulses carrying those values in order; ACK after each byte.
- STOP after 4 bits of a data byte -> no RxValid, RxData keeps its previous value, SDA_oe=0, Busy=0.
- Repeated START after the address ACK, then 0x3C write with 8'h5A -> re-enters ADDR, ACKs, RxData=8'h5A. Separately, assert Reset while SDA_oe=1 -> SDA_oe drops in the same cycle and all outputs return to reset values.
